// File: rtl/rf_banked_2r1w_pkg.sv
// Shared defaults and index-width helpers for the banked 2R1W register file.
package rf_banked_2r1w_pkg;

   localparam int unsigned DEF_WIDTH     = 65;
   localparam int unsigned DEF_LG_DEPTH  = 8;
   localparam int unsigned DEF_LG_NBANKS = 2;
   localparam int unsigned DEF_NLANES    = 1;

   function automatic int unsigned lane_width(input int unsigned width, input int unsigned nlanes);
      return width / nlanes;
   endfunction

   function automatic int unsigned row_width(input int unsigned lg_depth, input int unsigned lg_nbanks);
      return lg_depth - lg_nbanks;
   endfunction

endpackage

// File: rtl/rf_banked_2r1w_bank.sv
// One register-file bank: lane-mask expansion and active-high to active-low macro controls.
module rf_bank
   import rf_banked_2r1w_pkg::*;
#(
   parameter int unsigned WIDTH  = DEF_WIDTH,
   parameter int unsigned ROW_W  = 6,
   parameter int unsigned NLANES = DEF_NLANES
) (
   input  logic              clk,
   input  logic              ren,
   input  logic [ROW_W-1:0]  raddr,
   output logic [WIDTH-1:0]  rdata,
   input  logic              wen,
   input  logic [ROW_W-1:0]  waddr,
   input  logic [NLANES-1:0] wmask,
   input  logic [WIDTH-1:0]  wdata
);

   localparam int unsigned LANE_W = lane_width(WIDTH, NLANES);

   logic [WIDTH-1:0] bm;

   for (genvar i = 0; i < NLANES; i++) begin : g_mask
      assign bm[i*LANE_W +: LANE_W] = {LANE_W{wmask[i]}};
   end

   sram_1r1w #(.ADDR_W(ROW_W), .DATA_W(WIDTH)) u_sram (
      .clk   (clk),
      .csb0  (~ren),
      .addr0 (raddr),
      .dout0 (rdata),
      .csb1  (~wen),
      .web1  (~wen),
      .addr1 (waddr),
      .din1  (wdata),
      .bm1   (bm)
   );

endmodule

// File: rtl/sram_1r1w.sv
// Behavioural model of the 1R1W SRAM macro: active-low selects, per-bit write mask, registered read.
module sram_1r1w #(
   parameter int unsigned ADDR_W = 6,
   parameter int unsigned DATA_W = 65
) (
   input  logic              clk,
   input  logic              csb0,
   input  logic [ADDR_W-1:0] addr0,
   output logic [DATA_W-1:0] dout0,
   input  logic              csb1,
   input  logic              web1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] din1,
   input  logic [DATA_W-1:0] bm1
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   // Read returns pre-write contents when both ports hit the same row.
   always_ff @(posedge clk) begin
      if (!csb0) dout0 <= mem[addr0];
      if (!csb1 && !web1) mem[addr1] <= (mem[addr1] & ~bm1) | (din1 & bm1);
   end

endmodule

// File: rtl/rf_banked_2r1w.sv
// Banked 2R1W register file with port-0 priority arbitration and 1-cycle read latency.
// Define RF_BYPASS_EN for write-first same-address bypass; otherwise colliding reads stall.
module rf_banked_2r1w
   import rf_banked_2r1w_pkg::*;
#(
   parameter int unsigned WIDTH     = DEF_WIDTH,
   parameter int unsigned LG_DEPTH  = DEF_LG_DEPTH,
   parameter int unsigned LG_NBANKS = DEF_LG_NBANKS,
   parameter int unsigned NLANES    = DEF_NLANES
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                r0_val,
   output logic                r0_rdy,
   input  logic [LG_DEPTH-1:0] r0_addr,
   output logic                r0_dval,
   output logic [WIDTH-1:0]    r0_data,
   input  logic                r1_val,
   output logic                r1_rdy,
   input  logic [LG_DEPTH-1:0] r1_addr,
   output logic                r1_dval,
   output logic [WIDTH-1:0]    r1_data,
   input  logic                w_val,
   input  logic [LG_DEPTH-1:0] w_addr,
   input  logic [NLANES-1:0]   w_mask,
   input  logic [WIDTH-1:0]    w_data
);

   localparam int unsigned NBANKS = 2**LG_NBANKS;
   localparam int unsigned ROW_W  = row_width(LG_DEPTH, LG_NBANKS);

   logic [LG_NBANKS-1:0] r0_bank, r1_bank, w_bank;
   logic [ROW_W-1:0]     r0_row, r1_row, w_row;
   logic                 r1_conflict, r0_fire, r1_fire;
   logic [WIDTH-1:0]     bank_rdata [NBANKS];
   logic [LG_NBANKS-1:0] r0_bank_q, r1_bank_q;
   logic [WIDTH-1:0]     r0_hold, r1_hold, r0_rd, r1_rd;

   assign r0_bank = r0_addr[LG_NBANKS-1:0];
   assign r1_bank = r1_addr[LG_NBANKS-1:0];
   assign w_bank  = w_addr[LG_NBANKS-1:0];
   assign r0_row  = r0_addr[LG_DEPTH-1:LG_NBANKS];
   assign r1_row  = r1_addr[LG_DEPTH-1:LG_NBANKS];
   assign w_row   = w_addr[LG_DEPTH-1:LG_NBANKS];

   // Same bank, different address: port 1 yields; identical addresses share one read.
   assign r1_conflict = r0_val && (r0_bank == r1_bank) && (r0_addr != r1_addr);

`ifdef RF_BYPASS_EN
   assign r0_rdy = 1'b1;
   assign r1_rdy = ~r1_conflict;
`else
   assign r0_rdy = ~(w_val && (w_addr == r0_addr));
   assign r1_rdy = ~r1_conflict && ~(w_val && (w_addr == r1_addr));
`endif

   assign r0_fire = r0_val && r0_rdy;
   assign r1_fire = r1_val && r1_rdy;

   for (genvar b = 0; b < NBANKS; b++) begin : g_bank
      logic r0_hit, r1_hit;
      assign r0_hit = r0_fire && (r0_bank == LG_NBANKS'(b));
      assign r1_hit = r1_fire && (r1_bank == LG_NBANKS'(b));

      rf_bank #(.WIDTH(WIDTH), .ROW_W(ROW_W), .NLANES(NLANES)) u_bank (
         .clk   (clk),
         .ren   (r0_hit || r1_hit),
         .raddr (r0_hit ? r0_row : r1_row),
         .rdata (bank_rdata[b]),
         .wen   (w_val && (w_bank == LG_NBANKS'(b))),
         .waddr (w_row),
         .wmask (w_mask),
         .wdata (w_data)
      );
   end

   // Response valid pulses and the bank each response must be taken from.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r0_dval   <= 1'b0;
         r1_dval   <= 1'b0;
         r0_bank_q <= '0;
         r1_bank_q <= '0;
      end else begin
         r0_dval   <= r0_fire;
         r1_dval   <= r1_fire;
         r0_bank_q <= r0_bank;
         r1_bank_q <= r1_bank;
      end
   end

`ifdef RF_BYPASS_EN
   logic [WIDTH-1:0] w_bits, wdata_q, wbits_q;
   logic             hit0_q, hit1_q;

   for (genvar i = 0; i < NLANES; i++) begin : g_wbits
      assign w_bits[i*lane_width(WIDTH, NLANES) +: lane_width(WIDTH, NLANES)] =
         {lane_width(WIDTH, NLANES){w_mask[i]}};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hit0_q  <= 1'b0;
         hit1_q  <= 1'b0;
         wdata_q <= '0;
         wbits_q <= '0;
      end else begin
         hit0_q  <= r0_fire && w_val && (w_addr == r0_addr);
         hit1_q  <= r1_fire && w_val && (w_addr == r1_addr);
         wdata_q <= w_data;
         wbits_q <= w_bits;
      end
   end

   // Write-first merge: written lanes from the captured write, the rest from the SRAM.
   assign r0_rd = hit0_q ? ((bank_rdata[r0_bank_q] & ~wbits_q) | (wdata_q & wbits_q))
                         : bank_rdata[r0_bank_q];
   assign r1_rd = hit1_q ? ((bank_rdata[r1_bank_q] & ~wbits_q) | (wdata_q & wbits_q))
                         : bank_rdata[r1_bank_q];
`else
   assign r0_rd = bank_rdata[r0_bank_q];
   assign r1_rd = bank_rdata[r1_bank_q];
`endif

   // Capture each response so the data output holds between responses.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r0_hold <= '0;
         r1_hold <= '0;
      end else begin
         if (r0_dval) r0_hold <= r0_rd;
         if (r1_dval) r1_hold <= r1_rd;
      end
   end

   assign r0_data = r0_dval ? r0_rd : r0_hold;
   assign r1_data = r1_dval ? r1_rd : r1_hold;

endmodule

// File: tb/tb_rf_banked_2r1w.sv
// Directed self-checking bench for rf_banked_2r1w (WIDTH=68, NLANES=4 so lane masking is exercised).
module tb_rf_banked_2r1w;

   localparam int unsigned WIDTH     = 68;
   localparam int unsigned LG_DEPTH  = 8;
   localparam int unsigned LG_NBANKS = 2;
   localparam int unsigned NLANES    = 4;

   logic                clk = 1'b0;
   logic                reset_n;
   logic                r0_val, r0_rdy, r0_dval;
   logic [LG_DEPTH-1:0] r0_addr;
   logic [WIDTH-1:0]    r0_data;
   logic                r1_val, r1_rdy, r1_dval;
   logic [LG_DEPTH-1:0] r1_addr;
   logic [WIDTH-1:0]    r1_data;
   logic                w_val;
   logic [LG_DEPTH-1:0] w_addr;
   logic [NLANES-1:0]   w_mask;
   logic [WIDTH-1:0]    w_data;

   int errors = 0;
   int checks = 0;

   localparam logic [WIDTH-1:0] D5    = 68'h1_2345_6789_ABCD_EF01;
   localparam logic [WIDTH-1:0] A4    = 68'h4_4444_0000_1111_0004;
   localparam logic [WIDTH-1:0] A8    = 68'h8_8888_0000_2222_0008;
   localparam logic [WIDTH-1:0] A1    = 68'hA_0000_0000_0000_00A1;
   localparam logic [WIDTH-1:0] A2    = 68'hB_0000_0000_0000_00A2;
   localparam logic [WIDTH-1:0] A3    = 68'hC_0000_0000_0000_00A3;
   localparam logic [WIDTH-1:0] ONES  = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] MASKD = {17'h1FFFF, 17'h0, 17'h1FFFF, 17'h0};

   always #5 clk = ~clk;

   rf_banked_2r1w #(
      .WIDTH(WIDTH), .LG_DEPTH(LG_DEPTH), .LG_NBANKS(LG_NBANKS), .NLANES(NLANES)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .r0_val  (r0_val),
      .r0_rdy  (r0_rdy),
      .r0_addr (r0_addr),
      .r0_dval (r0_dval),
      .r0_data (r0_data),
      .r1_val  (r1_val),
      .r1_rdy  (r1_rdy),
      .r1_addr (r1_addr),
      .r1_dval (r1_dval),
      .r1_data (r1_data),
      .w_val   (w_val),
      .w_addr  (w_addr),
      .w_mask  (w_mask),
      .w_data  (w_data)
   );

   task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge; inputs change and outputs are sampled here.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      r0_val = 1'b0; r1_val = 1'b0; w_val = 1'b0;
      r0_addr = '0; r1_addr = '0; w_addr = '0; w_mask = '0; w_data = '0;
   endtask

   task automatic write(input logic [LG_DEPTH-1:0] a, input logic [NLANES-1:0] m,
                        input logic [WIDTH-1:0] d);
      idle();
      w_val = 1'b1; w_addr = a; w_mask = m; w_data = d;
      step();
      idle();
   endtask

   initial begin
      idle();
      reset_n = 1'b0;
      repeat (3) step();
      check("rst_r0_dval", WIDTH'(r0_dval), '0);
      check("rst_r1_dval", WIDTH'(r1_dval), '0);
      check("rst_r0_data", r0_data, '0);
      check("rst_r1_data", r1_data, '0);
      reset_n = 1'b1;
      step();

      // Basic write then read
      write(8'd5, 4'hF, D5);
      r0_val = 1'b1; r0_addr = 8'd5;
      #1 check("basic_rdy", WIDTH'(r0_rdy), WIDTH'(1'b1));
      step();
      idle();
      check("basic_dval", WIDTH'(r0_dval), WIDTH'(1'b1));
      check("basic_data", r0_data, D5);
      check("basic_r1_idle", WIDTH'(r1_dval), '0);
      step();
      check("hold_dval", WIDTH'(r0_dval), '0);
      check("hold_data", r0_data, D5);

      // Bank conflict: 4 and 8 are both bank 0
      write(8'd4, 4'hF, A4);
      write(8'd8, 4'hF, A8);
      r0_val = 1'b1; r0_addr = 8'd4; r1_val = 1'b1; r1_addr = 8'd8;
      #1 check("conf_r0_rdy", WIDTH'(r0_rdy), WIDTH'(1'b1));
      check("conf_r1_rdy", WIDTH'(r1_rdy), '0);
      step();
      r0_val = 1'b0;
      check("conf_r0_dval", WIDTH'(r0_dval), WIDTH'(1'b1));
      check("conf_r0_data", r0_data, A4);
      check("conf_r1_dval0", WIDTH'(r1_dval), '0);
      #1 check("conf_r1_rdy2", WIDTH'(r1_rdy), WIDTH'(1'b1));
      step();
      idle();
      check("conf_r1_dval", WIDTH'(r1_dval), WIDTH'(1'b1));
      check("conf_r1_data", r1_data, A8);

      // Same address on both ports is shared
      r0_val = 1'b1; r0_addr = 8'd4; r1_val = 1'b1; r1_addr = 8'd4;
      #1 check("share_r1_rdy", WIDTH'(r1_rdy), WIDTH'(1'b1));
      step();
      idle();
      check("share_r0_data", r0_data, A4);
      check("share_r1_dval", WIDTH'(r1_dval), WIDTH'(1'b1));
      check("share_r1_data", r1_data, A4);

      // Parallel reads of banks 1/2 with a write to bank 3
      write(8'd1, 4'hF, A1);
      write(8'd2, 4'hF, A2);
      r0_val = 1'b1; r0_addr = 8'd1; r1_val = 1'b1; r1_addr = 8'd2;
      w_val = 1'b1; w_addr = 8'd3; w_mask = 4'hF; w_data = A3;
      #1 check("par_rdy", WIDTH'({r0_rdy, r1_rdy}), WIDTH'(2'b11));
      step();
      idle();
      check("par_dval", WIDTH'({r0_dval, r1_dval}), WIDTH'(2'b11));
      check("par_r0_data", r0_data, A1);
      check("par_r1_data", r1_data, A2);
      r0_val = 1'b1; r0_addr = 8'd3;
      step();
      idle();
      check("par_w_data", r0_data, A3);

      // Same bank, different row: write 13 while reading 1 (both bank 1)
      r0_val = 1'b1; r0_addr = 8'd1;
      w_val = 1'b1; w_addr = 8'd13; w_mask = 4'hF; w_data = A4;
      #1 check("rowdiff_rdy", WIDTH'(r0_rdy), WIDTH'(1'b1));
      step();
      idle();
      check("rowdiff_data", r0_data, A1);
      r1_val = 1'b1; r1_addr = 8'd13;
      step();
      idle();
      check("rowdiff_wr", r1_data, A4);

      // Lane-masked write clears lanes 0 and 2
      write(8'd7, 4'hF, ONES);
      write(8'd7, 4'b0101, '0);
      r1_val = 1'b1; r1_addr = 8'd7;
      step();
      idle();
      check("mask_data", r1_data, MASKD);

      // Same-address write/read collision
      write(8'd9, 4'hF, 68'h55);
      r0_val = 1'b1; r0_addr = 8'd9;
      w_val = 1'b1; w_addr = 8'd9; w_mask = 4'hF; w_data = 68'hAA;
`ifdef RF_BYPASS_EN
      #1 check("coll_rdy", WIDTH'(r0_rdy), WIDTH'(1'b1));
      step();
      idle();
      check("coll_dval", WIDTH'(r0_dval), WIDTH'(1'b1));
      check("coll_data", r0_data, 68'hAA);
`else
      #1 check("coll_rdy", WIDTH'(r0_rdy), '0);
      step();
      w_val = 1'b0;
      check("coll_dval0", WIDTH'(r0_dval), '0);
      #1 check("coll_rdy2", WIDTH'(r0_rdy), WIDTH'(1'b1));
      step();
      idle();
      check("coll_dval", WIDTH'(r0_dval), WIDTH'(1'b1));
      check("coll_data", r0_data, 68'hAA);
`endif

      // Reset during an in-flight response
      step();
      r0_val = 1'b1; r0_addr = 8'd5; r1_val = 1'b1; r1_addr = 8'd2;
      step();
      idle();
      check("mid_dval_pre", WIDTH'(r0_dval), WIDTH'(1'b1));
      reset_n = 1'b0;
      #1 check("mid_dval", WIDTH'({r0_dval, r1_dval}), '0);
      check("mid_r0_data", r0_data, '0);
      check("mid_r1_data", r1_data, '0);
      step();
      reset_n = 1'b1;
      step();
      r0_val = 1'b1; r0_addr = 8'd5;
      step();
      idle();
      check("post_rst_data", r0_data, D5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
